// File: rtl/mips_debug_pkg.sv
// Shared definitions for the UART debug controller: host command bytes and state encoding.
package mips_debug_pkg;

  localparam logic [7:0] StartSignal      = 8'h01;
  localparam logic [7:0] ContinuosSignal  = 8'h02;
  localparam logic [7:0] StepByStepSignal = 8'h03;
  localparam logic [7:0] ReProgramSignal  = 8'h05;
  localparam logic [7:0] StepSignal       = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    PROGRAM,
    RUN,
    STEP_WAIT,
    STEP,
    DUMP_LOAD,
    DUMP_SEND,
    DUMP_WAIT
  } state_t;

endpackage

// File: rtl/debug_word_serializer.sv
// Streams NUM_WORDS debug words to the UART transmitter, MSB byte first,
// one byte per tx_start/tx_done handshake.
module debug_word_serializer
  import mips_debug_pkg::*;
#(
  parameter int LEN       = 32,
  parameter int NUM_WORDS = 36,
  parameter int SEL_W     = $clog2(NUM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic             done,
  output logic [SEL_W-1:0] dump_sel,
  input  logic [LEN-1:0]   dump_data,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_done
);

  localparam int BYTES  = LEN / 8;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [SEL_W-1:0]  LAST_WORD = SEL_W'(NUM_WORDS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);

  state_t              st;
  logic [SEL_W-1:0]    word_idx;
  logic [BYTE_W-1:0]   byte_idx;

  assign dump_sel = word_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      word_idx <= '0;
      byte_idx <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (st)
        IDLE: if (go) begin
          word_idx <= '0;
          byte_idx <= LAST_BYTE;
          st       <= DUMP_LOAD;
        end
        // dump_sel already points at word_idx, so dump_data is valid here
        DUMP_LOAD: begin
          tx_data  <= dump_data[{byte_idx, 3'b000} +: 8];
          tx_start <= 1'b1;
          st       <= DUMP_WAIT;
        end
        DUMP_WAIT: if (tx_done) begin
          if (byte_idx == '0) begin
            if (word_idx == LAST_WORD) begin
              done <= 1'b1;
              st   <= IDLE;
            end else begin
              word_idx <= word_idx + 1'b1;
              byte_idx <= LAST_BYTE;
              st       <= DUMP_LOAD;
            end
          end else begin
            byte_idx <= byte_idx - 1'b1;
            st       <= DUMP_LOAD;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mips_debug_unit.sv
// UART debug controller: decodes host commands, loads instruction memory,
// gates the pipeline clock-enable and triggers debug dumps.
module mips_debug_unit
  import mips_debug_pkg::*;
#(
  parameter int             LEN         = 32,
  parameter int             NUM_WORDS   = 36,
  parameter int             PROG_ADDR_W = 10,
  parameter logic [LEN-1:0] HALT_WORD   = {LEN{1'b1}}
) (
  input  logic                         CLK100MHZ,
  input  logic                         SWITCH_RESET,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_done,
  output logic [7:0]                   tx_data,
  output logic                         tx_start,
  input  logic                         tx_done,
  output logic                         cpu_enable,
  output logic                         cpu_reset,
  input  logic                         halt,
  output logic                         prog_we,
  output logic [PROG_ADDR_W-1:0]       prog_addr,
  output logic [LEN-1:0]               prog_data,
  output logic [$clog2(NUM_WORDS)-1:0] dump_sel,
  input  logic [LEN-1:0]               dump_data
);

  localparam int BYTES  = LEN / 8;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);

  state_t            state;
  logic [LEN-1:0]    word_sr;
  logic [LEN-1:0]    word_next;
  logic [BYTE_W-1:0] byte_cnt;
  logic              step_dump;
  logic              dump_go;
  logic              dump_done;

  assign word_next = (word_sr << 8) | LEN'(rx_data);

  always_ff @(posedge CLK100MHZ or posedge SWITCH_RESET) begin
    if (SWITCH_RESET) begin
      state      <= IDLE;
      word_sr    <= '0;
      byte_cnt   <= '0;
      step_dump  <= 1'b0;
      dump_go    <= 1'b0;
      cpu_enable <= 1'b0;
      cpu_reset  <= 1'b0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
    end else begin
      cpu_reset <= 1'b0;
      prog_we   <= 1'b0;
      dump_go   <= 1'b0;
      // address advances the cycle after each write strobe
      if (prog_we) prog_addr <= prog_addr + 1'b1;
      case (state)
        IDLE: begin
          cpu_enable <= 1'b0;
          if (rx_done) begin
            case (rx_data)
              StartSignal:      cpu_reset <= 1'b1;
              ContinuosSignal:  state <= RUN;
              StepByStepSignal: state <= STEP_WAIT;
              ReProgramSignal: begin
                state     <= PROGRAM;
                prog_addr <= '0;
                byte_cnt  <= '0;
              end
              default: ;
            endcase
          end
        end
        PROGRAM: if (rx_done) begin
          word_sr <= word_next;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt  <= '0;
            prog_data <= word_next;
            prog_we   <= 1'b1;
            if (word_next == HALT_WORD) state <= IDLE;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        RUN: begin
          if (halt) begin
            cpu_enable <= 1'b0;
            dump_go    <= 1'b1;
            step_dump  <= 1'b0;
            state      <= DUMP_SEND;
          end else begin
            cpu_enable <= 1'b1;
          end
        end
        STEP_WAIT: begin
          cpu_enable <= 1'b0;
          if (rx_done) begin
            if (rx_data == StepSignal) begin
              cpu_enable <= 1'b1;
              state      <= STEP;
            end else if (rx_data == ContinuosSignal) begin
              state <= RUN;
            end
          end
        end
        STEP: begin
          cpu_enable <= 1'b0;
          dump_go    <= 1'b1;
          step_dump  <= 1'b1;
          state      <= DUMP_SEND;
        end
        // halt is sampled at the end of the dump so a late-retiring halt still ends stepping
        DUMP_SEND: begin
          cpu_enable <= 1'b0;
          if (dump_done) state <= (step_dump && !halt) ? STEP_WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  debug_word_serializer #(
    .LEN       (LEN),
    .NUM_WORDS (NUM_WORDS)
  ) u_serializer (
    .clk       (CLK100MHZ),
    .rst       (SWITCH_RESET),
    .go        (dump_go),
    .done      (dump_done),
    .dump_sel  (dump_sel),
    .dump_data (dump_data),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done)
  );

endmodule

// File: doc/mips_debug_unit.md
Name: mips_debug_unit

Overview:
- UART-facing debug controller between the UART rx/tx pair and the MIPS pipeline in top_modular.
- Decodes host command bytes: start, continuous, step-by-step, reprogram and step.
- Loads instruction memory from the byte stream and gates the pipeline clock-enable.
- After each step or at halt, streams NUM_WORDS debug words back to the host, MSB byte first.
- Parametrised successor of the fixed 8-bit command input currently driven straight into the core.

Parameters:
- LEN, 32, debug/instruction word width; must be a multiple of 8; BYTES = LEN/8.
- NUM_WORDS, 36, number of debug words sent per dump (registers, PC, latches).
- PROG_ADDR_W, 10, instruction memory address width.
- HALT_WORD, 32'hFFFF_FFFF, instruction word that terminates a reprogram stream.

Ports:
- CLK100MHZ  in  1  system clock.
- SWITCH_RESET  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_done  in  1  one-cycle pulse: rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle pulse: launch tx_data.
- tx_done  in  1  one-cycle pulse: previous byte fully sent.
- cpu_enable  out  1  pipeline clock-enable.
- cpu_reset  out  1  one-cycle synchronous reset pulse to the pipeline.
- halt  in  1  core has retired the halt instruction.
- prog_we  out  1  instruction memory write strobe.
- prog_addr  out  PROG_ADDR_W  instruction memory write address.
- prog_data  out  LEN  instruction memory write data.
- dump_sel  out  clog2(NUM_WORDS)  debug word index.
- dump_data  in  LEN  debug word; combinational from dump_sel, valid the same cycle.

Behaviour:
- Reset: all outputs 0. State IDLE. Counters cleared. Any partial word, step or dump in progress is discarded.
- Commands are decoded only on rx_done:
  - 0x01 StartSignal
  - 0x02 ContinuosSignal
  - 0x03 StepByStepSignal
  - 0x05 ReProgramSignal
  - 0x06 StepSignal
- Any other value is ignored, and the unit stays in its current state.
- IDLE:
  - 0x01: cpu_reset pulses high one cycle; stay in IDLE.
  - 0x02: go to RUN.
  - 0x03: go to STEP_WAIT.
  - 0x05: go to PROGRAM, prog_addr=0.
  - 0x06: ignored.
- PROGRAM:
  - Each rx_done shifts the byte into the word, MSB first.
  - On the BYTES-th byte: prog_data=word, prog_we high one cycle, prog_addr increments on the following cycle.
  - prog_addr wraps modulo 2^PROG_ADDR_W.
  - If the assembled word equals HALT_WORD, it is written, then the unit returns to IDLE.
  - Command decoding is suspended in PROGRAM; every byte is data.
- RUN:
  - cpu_enable=1 from the cycle after entry.
  - On the first cycle halt=1: cpu_enable=0 that same cycle (registered, so the core sees one more enabled edge at most), then DUMP, then IDLE.
- STEP_WAIT:
  - cpu_enable=0.
  - 0x06: go to STEP (cpu_enable=1 for exactly one cycle), then DUMP, then back to STEP_WAIT.
  - If halt=1 after the step, the return target is IDLE instead.
  - 0x02 in STEP_WAIT switches to RUN; 0x01/0x03/0x05 are ignored.
- DUMP:
  - For dump_sel = 0 to NUM_WORDS-1 and byte = BYTES-1 down to 0: tx_data = dump_data[8*byte +: 8].
  - tx_start pulses one cycle, then the unit waits for tx_done before the next byte.
  - Exactly NUM_WORDS*BYTES bytes per dump.
  - rx_done during DUMP is dropped.
  - cpu_enable=0 throughout.
- tx_done outside DUMP is ignored.
- rx_done coincident with halt in RUN: halt takes precedence; the byte is dropped.

Decomposition:
- Shared package mips_debug_pkg holds:
  - command byte constants: StartSignal, ContinuosSignal, StepByStepSignal, ReProgramSignal, StepSignal;
  - the state encoding: IDLE, PROGRAM, RUN, STEP_WAIT, STEP, DUMP_LOAD, DUMP_SEND, DUMP_WAIT.
- One sub-module, debug_word_serializer: LEN-to-byte DUMP engine with tx_start/tx_done handshake and word/byte counters. It is started by a go pulse and returns a done pulse.

Test Plan:
- Reset, then 0x05 followed by bytes 20 01 00 05 / FF FF FF FF → two prog_we pulses: addr0=0x20010005, addr1=0xFFFFFFFF; state returns to IDLE; the next 0x05 restarts at addr0.
- 0x02 with halt raised 50 cycles later → cpu_enable high for about 50 cycles, low the cycle after halt. Then 4*NUM_WORDS tx_start pulses; with dump_data=0xA1B2C3D4 for word 0, the first bytes are A1, B2, C3, D4.
- 0x03 then 0x06 twice → exactly one cpu_enable cycle per 0x06, each followed by a full dump; 0x06 sent mid-dump produces no extra step.
- 0x01 in IDLE → single cpu_reset pulse, cpu_enable stays 0; 0x07 → no output change.
- SWITCH_RESET asserted mid-dump and mid-program (after 2 of 4 bytes) → all outputs 0 immediately. After release, 0x05 plus 4 bytes writes a clean word at addr 0.
- Step with halt set → dump, then the unit is in IDLE: 0x06 ignored, 0x02 accepted.
